sdp_x_alu_out_skid: RTL

- Consumer stage directly downstream of the SDP X-path ALU core's chn_alu_out channel.
- Accepts ALU result packets on a valid/ready handshake and buffers them in a 2-entry skid buffer with registered ready.
- Forwards packets in order to the multiplier stage input channel (chn_mul_in).
- Counts packets per layer, tags the final packet with a last flag, and pulses layer-done when the final packet leaves.

---
 rtl/sdp_x_pkg.sv | 17 +
 rtl/sdp_x_skid2.sv | 79 +++++++
 rtl/sdp_x_alu_out_skid.sv | 109 ++++++++++
 3 files changed

// File: rtl/sdp_x_pkg.sv
// Shared definitions for the SDP X-path ALU output consumer stage.
package sdp_x_pkg;

  // Default packet width: 16 lanes of 32 bits.
  localparam int SDP_X_DW = 512;

  // Default width of the element counters and the element-count config.
  localparam int SDP_X_CW = 32;

  // Layer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sdp_x_state_e;

endpackage

// File: rtl/sdp_x_skid2.sv
// Generic 2-entry skid buffer with a registered upstream ready.
// The head entry drives the output directly, so output data is stable while
// downstream stalls. accept_en is the caller's next-cycle permission to accept;
// it is combined with next-cycle occupancy so ready never has a combinational
// path from either side of the buffer.
module sdp_x_skid2
  import sdp_x_pkg::*;
#(
  parameter int DW = SDP_X_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_pd,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_pd,
  input  logic          accept_en
);

  logic [1:0]    occ;
  logic [1:0]    occ_nxt;
  logic [DW-1:0] head;
  logic [DW-1:0] head_nxt;
  logic [DW-1:0] tail;
  logic [DW-1:0] tail_nxt;
  logic          push;
  logic          pop;

  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  assign out_vld = (occ != 2'd0);
  assign out_pd  = head;

  // Next occupancy and entry contents; a simultaneous push and pop keeps
  // occupancy and shifts the tail forward so FIFO order is preserved.
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    case ({push, pop})
      2'b10: begin
        if (occ == 2'd0) head_nxt = in_pd;
        else             tail_nxt = in_pd;
        occ_nxt = occ + 2'd1;
      end
      2'b01: begin
        head_nxt = tail;
        occ_nxt  = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          head_nxt = in_pd;
        end else begin
          head_nxt = tail;
          tail_nxt = in_pd;
        end
      end
      default: ;
    endcase
  end

  // Entry registers, occupancy, and the registered ready for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      head   <= '0;
      tail   <= '0;
      in_rdy <= 1'b0;
    end else begin
      occ    <= occ_nxt;
      head   <= head_nxt;
      tail   <= tail_nxt;
      in_rdy <= accept_en & (occ_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/sdp_x_alu_out_skid.sv
// Consumer stage for the SDP X-path ALU output channel. Buffers ALU result
// packets in a 2-entry skid, forwards them in order to the multiplier input,
// counts packets per layer, flags the final packet and pulses layer_done.
module sdp_x_alu_out_skid
  import sdp_x_pkg::*;
#(
  parameter int DW = SDP_X_DW,
  parameter int CW = SDP_X_CW
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          op_start,
  input  logic [CW-1:0] cfg_elem_num_m1,
  input  logic          chn_alu_out_vld,
  output logic          chn_alu_out_rdy,
  input  logic [DW-1:0] chn_alu_out_pd,
  output logic          chn_mul_in_vld,
  input  logic          chn_mul_in_rdy,
  output logic [DW-1:0] chn_mul_in_pd,
  output logic          chn_mul_in_last,
  output logic          layer_done,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  sdp_x_state_e  state;
  sdp_x_state_e  state_nxt;
  logic [CW-1:0] elem_m1;
  logic [CW-1:0] elem_m1_nxt;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] in_cnt_nxt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_nxt;
  logic          layer_done_nxt;
  logic          accept_en;
  logic          accept;
  logic          fire;

  assign accept          = chn_alu_out_vld & chn_alu_out_rdy;
  assign fire            = chn_mul_in_vld & chn_mul_in_rdy;
  assign chn_mul_in_last = chn_mul_in_vld & (out_cnt == elem_m1);
  assign busy            = (state != IDLE);

  sdp_x_skid2 #(
    .DW (DW)
  ) u_skid (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .in_vld    (chn_alu_out_vld),
    .in_rdy    (chn_alu_out_rdy),
    .in_pd     (chn_alu_out_pd),
    .out_vld   (chn_mul_in_vld),
    .out_rdy   (chn_mul_in_rdy),
    .out_pd    (chn_mul_in_pd),
    .accept_en (accept_en)
  );

  // Layer sequencing, counters and the next-cycle accept permission. Counts are
  // compared by equality so an all-ones element count never wraps mid-layer.
  always_comb begin
    state_nxt      = state;
    elem_m1_nxt    = elem_m1;
    in_cnt_nxt     = in_cnt;
    out_cnt_nxt    = out_cnt;
    layer_done_nxt = 1'b0;
    if (accept) in_cnt_nxt = in_cnt + CNT_ONE;
    if (fire)   out_cnt_nxt = out_cnt + CNT_ONE;
    case (state)
      IDLE: begin
        if (op_start) begin
          state_nxt   = RUN;
          elem_m1_nxt = cfg_elem_num_m1;
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
        end
      end
      RUN: begin
        if (accept && (in_cnt == elem_m1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fire && chn_mul_in_last) begin
          state_nxt      = IDLE;
          layer_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept_en = (state_nxt == RUN) && (in_cnt_nxt <= elem_m1_nxt);
  end

  // State, latched config, counters and the registered done pulse.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state      <= IDLE;
      elem_m1    <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      layer_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      elem_m1    <= elem_m1_nxt;
      in_cnt     <= in_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
      layer_done <= layer_done_nxt;
    end
  end

endmodule
